// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives a request; the slave (the subtractor) returns the result and bit stream.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             bit_out;
  logic             bit_vld;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, bit_out, bit_vld
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, bit_out, bit_vld
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), LSB first, one bit per clock,
// using a single borrow flop. Final borrow is 1 when a < b (unsigned).
// The last difference bit is presented on bit_out in the same cycle as the done pulse,
// so the observation stream always carries all WIDTH bits.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, busy_q, done_q, borrow_q, bit_out_q, bit_vld_q;

  logic             d_d, bout_d;
  logic [WIDTH-1:0] res_d;

  // One full-subtractor cell on the current LSBs plus the result shifted in from the MSB side.
  always_comb begin
    d_d    = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    bout_d = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
    res_d  = {d_d, res_q[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_q     <= '0;
      diff_q    <= '0;
      cnt_q     <= '0;
      brw_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      borrow_q  <= 1'b0;
      bit_out_q <= 1'b0;
      bit_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          bit_vld_q <= 1'b0;
          if (bus.start) begin
            // Previous diff/borrow stay visible until the new result lands.
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q    <= a_sr_q >> 1;
          b_sr_q    <= b_sr_q >> 1;
          brw_q     <= bout_d;
          res_q     <= res_d;
          bit_out_q <= d_d;
          bit_vld_q <= 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff_q   <= res_d;
            borrow_q <= bout_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q    <= 1'b0;
          bit_vld_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.diff    = diff_q;
  assign bus.borrow  = borrow_q;
  assign bus.bit_out = bit_out_q;
  assign bus.bit_vld = bit_vld_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed corner cases plus randomized operations,
// checked every cycle against a transaction-level model of the subtractor.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) ifc ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: p = cycles since the accepted start (0 = idle). Result is plain a-b arithmetic.
  int         p = 0;
  bit         mval = 0;
  logic [W-1:0] m_res = '0, m_diff = '0;
  logic       m_bw = 1'b0, m_borrow = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      p = 0; m_diff = '0; m_borrow = 1'b0; mval = 1;
    end else if (p == 0) begin
      if (ifc.start) begin
        m_res = ifc.a - ifc.b;
        m_bw  = (ifc.a < ifc.b);
        p = 1;
      end
    end else if (p <= W) begin
      p++;
      if (p == W + 1) begin m_diff = m_res; m_borrow = m_bw; end
    end else begin
      p = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mval) begin
      chk("busy",    ifc.busy,    (p >= 1 && p <= W));
      chk("done",    ifc.done,    (p == W + 1));
      chk("bit_vld", ifc.bit_vld, (p >= 2 && p <= W + 1));
      if (p >= 2 && p <= W + 1) chk("bit_out", ifc.bit_out, m_res[p-2]);
      chk("diff",    ifc.diff,    m_diff);
      chk("borrow",  ifc.borrow,  m_borrow);
    end
  end

  // Runs one operation; collects the bit stream; optionally disturbs inputs mid-SHIFT.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb,
                       output logic [W-1:0] bits, output bit seen_done);
    int n;
    n = 0; bits = '0; seen_done = 0;
    @(negedge clk); ifc.a = a; ifc.b = b; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      if (disturb && i == 3) begin
        ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.start = 1'b1;
      end
      if (disturb && i == 4) ifc.start = 1'b0;
      @(negedge clk);
      if (ifc.bit_vld && n < W) begin bits[n] = ifc.bit_out; n++; end
      if (ifc.done) begin seen_done = 1; break; end
    end
    ifc.start = 1'b0;
    chk("op_done_within_bound", seen_done, 1'b1);
  endtask

  logic [W-1:0] bits;
  bit           sd;
  int           dcnt, t_first, t_second;

  initial begin
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", ifc.busy, 1'b0);
    chk("reset_done", ifc.done, 1'b0);
    chk("reset_diff", ifc.diff, 8'h00);
    chk("reset_borrow", ifc.borrow, 1'b0);
    chk("reset_bit_out", ifc.bit_out, 1'b0);
    chk("reset_bit_vld", ifc.bit_vld, 1'b0);
    rst = 1'b0;

    // T1
    do_op(8'h05, 8'h03, 0, bits, sd);
    chk("T1_diff", ifc.diff, 8'h02);
    chk("T1_borrow", ifc.borrow, 1'b0);
    chk("T1_model_diff", m_diff, 8'h02);
    // T2: stream LSB first 0,1,1,1,1,1,1,1
    do_op(8'h03, 8'h05, 0, bits, sd);
    chk("T2_diff", ifc.diff, 8'hFE);
    chk("T2_borrow", ifc.borrow, 1'b1);
    chk("T2_stream", bits, 8'hFE);
    chk("T2_model_borrow", m_borrow, 1'b1);
    // T3 corners
    do_op(8'h00, 8'h00, 0, bits, sd);
    chk("T3a", {ifc.borrow, ifc.diff}, 9'h000);
    do_op(8'hFF, 8'h01, 0, bits, sd);
    chk("T3b", {ifc.borrow, ifc.diff}, 9'h0FE);
    do_op(8'h00, 8'h01, 0, bits, sd);
    chk("T3c", {ifc.borrow, ifc.diff}, 9'h1FF);
    do_op(8'h80, 8'h7F, 0, bits, sd);
    chk("T3d", {ifc.borrow, ifc.diff}, 9'h001);

    // T4: start held 20 cycles -> two ops, done pulses 10 cycles apart
    @(negedge clk); @(negedge clk);
    ifc.a = 8'h10; ifc.b = 8'h01; ifc.start = 1'b1;
    dcnt = 0; t_first = -1; t_second = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 19) ifc.start = 1'b0;
      if (ifc.done) begin
        dcnt++;
        if (t_first < 0) t_first = i; else t_second = i;
        chk("T4_diff", ifc.diff, 8'h0F);
      end
    end
    ifc.start = 1'b0;
    chk("T4_done_count", dcnt, 2);
    chk("T4_done_spacing", t_second - t_first, 10);
    repeat (W + 3) @(negedge clk);

    // T5: disturbance mid-SHIFT ignored
    do_op(8'h5A, 8'h33, 1, bits, sd);
    chk("T5_diff", ifc.diff, 8'h27);
    chk("T5_borrow", ifc.borrow, 1'b0);

    // T6: reset at SHIFT cycle 4
    @(negedge clk); ifc.a = 8'h40; ifc.b = 8'h11; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("T6_busy", ifc.busy, 1'b0);
    chk("T6_done", ifc.done, 1'b0);
    chk("T6_diff", ifc.diff, 8'h00);
    chk("T6_borrow", ifc.borrow, 1'b0);
    chk("T6_bit_vld", ifc.bit_vld, 1'b0);
    dcnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (ifc.done) dcnt++;
    end
    chk("T6_no_done", dcnt, 0);
    do_op(8'h09, 8'h04, 0, bits, sd);
    chk("T6_after_diff", ifc.diff, 8'h05);

    // Random operations, some with mid-op disturbance.
    for (int k = 0; k < 40; k++) begin
      do_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)), bits, sd);
      chk("rand_stream", bits, ifc.diff);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
